// File: rtl/hd_kernel_rr_scheduler.sv
// Round-robin scheduler that shares one hd08 FHE kernel (y0 = x0^x1^...^x7) among NREQ requesters.
// Define HD_KERNEL_PIPE_EN to add a PIPE stage between the kernel output and the response slot.
module hd_kernel_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_y,
  output logic [2:0]           rsp_src,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  localparam int IW = 3;

`ifdef HD_KERNEL_PIPE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, PIPE = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, HOLD = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr;
  logic [7:0]      op_data;
  logic [TAGW-1:0] op_tag;
  logic [IW-1:0]   op_src;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [7:0]      sel_data;
  logic [TAGW-1:0] sel_tag;
  logic            can_issue;
  logic            accept;
`ifdef HD_KERNEL_PIPE_EN
  logic            pipe_y;
`endif

  function automatic logic hd08(input logic [7:0] x);
    return ^x;
  endfunction

  // Two passes give the wrap-around scan: first from ptr upward, then from 0.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && i >= int'(ptr) && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_tag  = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  assign can_issue = (state_q == IDLE) || (state_q == HOLD && rsp_ready);
  assign accept    = can_issue && gnt_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (gnt_idx == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EVAL;
`ifdef HD_KERNEL_PIPE_EN
      EVAL: state_d = PIPE;
      PIPE: state_d = HOLD;
`else
      EVAL: state_d = HOLD;
`endif
      HOLD: if (rsp_ready) state_d = accept ? EVAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= IDLE;
      ptr      <= '0;
      op_data  <= '0;
      op_tag   <= '0;
      op_src   <= '0;
      rsp_y    <= 1'b0;
      rsp_src  <= '0;
      rsp_tag  <= '0;
      ops_done <= '0;
`ifdef HD_KERNEL_PIPE_EN
      pipe_y   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_data <= sel_data;
        op_tag  <= sel_tag;
        op_src  <= gnt_idx;
        ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
`ifdef HD_KERNEL_PIPE_EN
      if (state_q == EVAL) pipe_y <= hd08(op_data);
      if (state_q == PIPE) begin
        rsp_y   <= pipe_y;
        rsp_src <= op_src;
        rsp_tag <= op_tag;
      end
`else
      if (state_q == EVAL) begin
        rsp_y   <= hd08(op_data);
        rsp_src <= op_src;
        rsp_tag <= op_tag;
      end
`endif
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_kernel_rr_scheduler.sv
// Directed self-checking bench for hd_kernel_rr_scheduler; CNTW is shrunk to 8 so the counter wrap
// is reachable. Latency counts the accept edge as edge 1.
module tb_hd_kernel_rr_scheduler;
  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int CNTW = 8;
`ifdef HD_KERNEL_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [8*NREQ-1:0]    req_data = '0;
  logic [TAGW*NREQ-1:0] req_tag = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic                 rsp_y;
  logic [2:0]           rsp_src;
  logic [TAGW-1:0]      rsp_tag;
  logic                 busy;
  logic [CNTW-1:0]      ops_done;

  int              errors = 0;
  int              checks = 0;
  logic [CNTW-1:0] exp_ops = '0;

  hd_kernel_rr_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_src(rsp_src), .rsp_tag(rsp_tag), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Golden hd08: odd number of set operand bits gives y0 = 1.
  function automatic logic golden(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) if (x[i]) n++;
    return (n % 2) == 1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ops = '0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_y !== 1'b0 || rsp_src !== 3'd0 ||
        rsp_tag !== '0 || busy !== 1'b0 || ops_done !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b y=%b src=%0d tag=%h busy=%b ops=%0d, all required 0",
               name, req_ready, rsp_valid, rsp_y, rsp_src, rsp_tag, busy, ops_done);
    end
  endtask

  // Runs one op from a single requester; called and returns at a negedge.
  task automatic run_op(input int src, input logic [7:0] d, input logic [3:0] t,
                        output logic y, output logic [2:0] s, output logic [3:0] tg,
                        output int lat, output bit ok);
    ok = 1'b0; lat = 0; y = 1'bx; s = 'x; tg = 'x;
    req_valid = '0;
    req_valid[src] = 1'b1;
    req_data[8*src +: 8] = d;
    req_tag[TAGW*src +: TAGW] = t;
    rsp_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[src]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin req_valid = '0; return; end
    @(posedge clk); lat = 1;
    @(negedge clk); req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!ok) return;
    y = rsp_y; s = rsp_src; tg = rsp_tag;
    rsp_ready = 1'b1;
    @(posedge clk); exp_ops++;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic y; logic [2:0] s; logic [3:0] tg; int lat; bit ok;
    run_op(0, 8'h00, 4'h5, y, s, tg, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done: ok=%b required 1", ok); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, LAT); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL single_y: got %b required 0", y); end
    checks++; if (s !== 3'd0) begin errors++; $display("FAIL single_src: got %0d required 0", s); end
    checks++; if (tg !== 4'h5) begin errors++; $display("FAIL single_tag: got %h required 5", tg); end
    checks++; if (ops_done !== 8'd1) begin errors++; $display("FAIL single_ops_done: got %0d required 1", ops_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_kernel_points();
    logic y; logic [2:0] s; logic [3:0] tg; int lat; bit ok;
    run_op(2, 8'h01, 4'h9, y, s, tg, lat, ok);
    checks++; if (!ok || y !== 1'b1 || s !== 3'd2 || tg !== 4'h9) begin
      errors++; $display("FAIL op_01_req2: ok=%b y=%b src=%0d tag=%h required y=1 src=2 tag=9", ok, y, s, tg); end
    run_op(1, 8'hFF, 4'hC, y, s, tg, lat, ok);
    checks++; if (!ok || y !== 1'b0 || s !== 3'd1 || tg !== 4'hC) begin
      errors++; $display("FAIL op_ff_req1: ok=%b y=%b src=%0d tag=%h required y=0 src=1 tag=c", ok, y, s, tg); end
    run_op(3, 8'h80, 4'h3, y, s, tg, lat, ok);
    checks++; if (!ok || y !== 1'b1 || s !== 3'd3 || tg !== 4'h3) begin
      errors++; $display("FAIL op_80_req3: ok=%b y=%b src=%0d tag=%h required y=1 src=3 tag=3", ok, y, s, tg); end
    checks++; if (ops_done !== 8'd4) begin errors++; $display("FAIL points_ops_done: got %0d required 4", ops_done); end
  endtask

  task automatic test_idle_boundary();
    rsp_ready = 1'b1;
    repeat (3) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL idle_quiet: rdy=%b busy=%b vld=%b required 0", req_ready, busy, rsp_valid); end
      @(negedge clk);
    end
    checks++; if (ops_done !== exp_ops) begin
      errors++; $display("FAIL idle_rsp_ready_ignored: ops=%0d required %0d", ops_done, exp_ops); end
    rsp_ready = 1'b0;
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pulse_grant: got %b required 0010", req_ready); end
    #1 req_valid = '0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dropped_valid: busy=%b required 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] dv [NREQ];
    dv[0] = 8'h00; dv[1] = 8'h01; dv[2] = 8'h03; dv[3] = 8'h07;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_data[8*i +: 8] = dv[i];
      req_tag[TAGW*i +: TAGW] = 4'(i + 1);
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c <= 4 * LAT; c++) begin
      logic [3:0] er; logic ev; int ps;
      #1;
      er = (c % LAT == 0) ? 4'(1 << ((c / LAT) % NREQ)) : 4'b0000;
      ev = (c % LAT == 0) && (c > 0);
      checks++; if (req_ready !== er) begin
        errors++; $display("FAIL rr_grant cycle %0d: got %b required %b", c, req_ready, er); end
      checks++; if (rsp_valid !== ev) begin
        errors++; $display("FAIL rr_valid cycle %0d: got %b required %b", c, rsp_valid, ev); end
      if (ev) begin
        ps = (c / LAT - 1) % NREQ;
        checks++; if (rsp_src !== 3'(ps) || rsp_y !== golden(dv[ps]) || rsp_tag !== 4'(ps + 1)) begin
          errors++; $display("FAIL rr_result cycle %0d: src=%0d y=%b tag=%h required src=%0d y=%b tag=%h",
                             c, rsp_src, rsp_y, rsp_tag, ps, golden(dv[ps]), ps + 1); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (LAT) @(negedge clk);
    exp_ops = exp_ops + 8'd5;
    #1;
    checks++; if (busy !== 1'b0 || ops_done !== exp_ops) begin
      errors++; $display("FAIL rr_drain: busy=%b ops=%0d required busy=0 ops=%0d", busy, ops_done, exp_ops); end
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; req_data[15:8] = 8'h0F; req_tag[7:4] = 4'hA; rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b required 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100; req_data[23:16] = 8'h10; req_tag[11:8] = 4'hB;
    repeat (LAT - 1) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_eval: rdy=%b vld=%b required 0", req_ready, rsp_valid); end
      @(negedge clk);
    end
    repeat (5) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_y !== 1'b0 || rsp_src !== 3'd1 || rsp_tag !== 4'hA ||
                    req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold: vld=%b y=%b src=%0d tag=%h rdy=%b busy=%b required 1 0 1 a 0000 1",
                           rsp_valid, rsp_y, rsp_src, rsp_tag, req_ready, busy); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_b2b_grant: got %b required 0100", req_ready); end
    @(negedge clk);
    exp_ops++;
    rsp_ready = 1'b0; req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || ops_done !== exp_ops) begin
      errors++; $display("FAIL bp_b2b_eval: vld=%b busy=%b ops=%0d required 0 1 %0d", rsp_valid, busy, ops_done, exp_ops); end
    repeat (LAT - 1) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_y !== 1'b1 || rsp_src !== 3'd2 || rsp_tag !== 4'hB) begin
      errors++; $display("FAIL bp_second: vld=%b y=%b src=%0d tag=%h required 1 1 2 b", rsp_valid, rsp_y, rsp_src, rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_ops++;
    rsp_ready = 1'b0; #1;
    checks++; if (busy !== 1'b0 || ops_done !== exp_ops) begin
      errors++; $display("FAIL bp_end: busy=%b ops=%0d required 0 %0d", busy, ops_done, exp_ops); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_data[23:16] = 8'h33; req_tag[11:8] = 4'h7; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant_eval: got %b required 0100", req_ready); end
    @(negedge clk);
    req_valid = '0; rst_n = 1'b0; #1;
    check_all_zero("reset_in_eval");
    exp_ops = '0;
    rst_n = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_after_eval: got %b required 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant_hold: got %b required 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (LAT - 1) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_in_hold: vld=%b required 1", rsp_valid); end
    rst_n = 1'b0; #1;
    check_all_zero("reset_in_hold");
    rst_n = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_after_hold: got %b required 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_sweep_wrap();
    logic y; logic [2:0] s; logic [3:0] tg; int lat; bit ok;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      run_op(i % NREQ, 8'(i), 4'(i), y, s, tg, lat, ok);
      checks++;
      if (!ok || y !== golden(8'(i)) || s !== 3'(i % NREQ) || tg !== 4'(i) || lat !== LAT) begin
        errors++; bad++;
        if (bad < 8) $display("FAIL sweep op %02h: ok=%b y=%b src=%0d tag=%h lat=%0d required y=%b src=%0d tag=%h lat=%0d",
                              i, ok, y, s, tg, lat, golden(8'(i)), i % NREQ, i % 16, LAT);
      end
      if (i == 254) begin
        checks++; if (ops_done !== 8'hFF) begin errors++; $display("FAIL ops_preload: got %h required ff", ops_done); end
      end
    end
    checks++; if (ops_done !== 8'h00) begin errors++; $display("FAIL ops_wrap: got %h required 00", ops_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_kernel_points();
    test_idle_boundary();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sweep_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
